// File: rtl/calc_pkg.sv
// Shared opcodes, FSM state encoding and default sizes for the RPN stack calculator.
package calc_pkg;

  localparam int CALC_WIDTH = 16;
  localparam int CALC_DEPTH = 8;

  localparam logic [2:0] OP_DIGIT = 3'd0;
  localparam logic [2:0] OP_ENTER = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [2:0] OP_DROP  = 3'd5;
  localparam logic [2:0] OP_DUP   = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PUSH = 2'd1;
  localparam logic [1:0] ST_OP   = 2'd2;

  function automatic logic is_binary(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational two-operand ALU: a op b, truncated to WIDTH bits.
module calc_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = a * b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/stack_calc_core.sv
// RPN calculator engine: hex digit entry, register-based operand stack and a
// three-state IDLE/PUSH/OP sequencer driving the displayed value.
module stack_calc_core
  import calc_pkg::*;
#(
  parameter int DEPTH = CALC_DEPTH,
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  input  logic [2:0]                 cmd_op,
  input  logic [3:0]                 cmd_digit,
  output logic                       cmd_ready,
  output logic [WIDTH-1:0]           numbers,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       entry_active,
  output logic                       err_overflow,
  output logic                       err_underflow
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] DEPTH_S = SPW'(DEPTH);
  localparam logic [SPW-1:0] ONE_S   = SPW'(1);
  localparam logic [SPW-1:0] TWO_S   = SPW'(2);

  logic [WIDTH-1:0] stack [DEPTH];
  logic [1:0]       state, state_n;
  logic [2:0]       op_q, op_n;
  logic [SPW-1:0]   sp, sp_n;
  logic [WIDTH-1:0] entry, entry_n;
  logic             active_n, ovf_n, unf_n;
  logic [WIDTH-1:0] numbers_n;

  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;

  logic [IW-1:0]    ix_sp, ix_top, ix_a, ix_top_n;
  logic [WIDTH-1:0] alu_res;

  assign ix_sp    = IW'(sp);
  assign ix_top   = IW'(sp - ONE_S);
  assign ix_a     = IW'(sp - TWO_S);
  assign ix_top_n = IW'(sp_n - ONE_S);

  calc_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (stack[ix_a]),
    .b      (stack[ix_top]),
    .op     (op_q),
    .result (alu_res)
  );

  assign cmd_ready = (state == ST_IDLE);
  assign depth     = sp;

  always_comb begin
    state_n  = state;
    op_n     = op_q;
    sp_n     = sp;
    entry_n  = entry;
    active_n = entry_active;
    ovf_n    = err_overflow;
    unf_n    = err_underflow;
    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_data  = '0;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_DIGIT: begin
              entry_n  = {entry[WIDTH-5:0], cmd_digit};
              active_n = 1'b1;
            end
            OP_CLEAR: begin
              sp_n     = '0;
              entry_n  = '0;
              active_n = 1'b0;
              ovf_n    = 1'b0;
              unf_n    = 1'b0;
            end
            default: begin
              op_n = cmd_op;
              if (entry_active)
                state_n = ST_PUSH;
              else if (cmd_op != OP_ENTER)
                state_n = ST_OP;
            end
          endcase
        end
      end

      ST_PUSH: begin
        // The pending entry is consumed whether or not it fits.
        entry_n  = '0;
        active_n = 1'b0;
        if (sp < DEPTH_S) begin
          wr_en   = 1'b1;
          wr_idx  = ix_sp;
          wr_data = entry;
          sp_n    = sp + ONE_S;
          state_n = (op_q == OP_ENTER) ? ST_IDLE : ST_OP;
        end else begin
          ovf_n   = 1'b1;
          state_n = ST_IDLE;
        end
      end

      ST_OP: begin
        state_n = ST_IDLE;
        if (is_binary(op_q)) begin
          if (sp >= TWO_S) begin
            wr_en   = 1'b1;
            wr_idx  = ix_a;
            wr_data = alu_res;
            sp_n    = sp - ONE_S;
          end else begin
            unf_n = 1'b1;
          end
        end else if (op_q == OP_DROP) begin
          if (sp >= ONE_S) sp_n = sp - ONE_S;
          else             unf_n = 1'b1;
        end else if (op_q == OP_DUP) begin
          if (sp < ONE_S) begin
            unf_n = 1'b1;
          end else if (sp >= DEPTH_S) begin
            ovf_n = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_idx  = ix_sp;
            wr_data = stack[ix_top];
            sp_n    = sp + ONE_S;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // Display value follows the post-update state; a write always lands on the new top.
    if (active_n)
      numbers_n = entry_n;
    else if (sp_n != '0)
      numbers_n = wr_en ? wr_data : stack[ix_top_n];
    else
      numbers_n = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      op_q          <= OP_DIGIT;
      sp            <= '0;
      entry         <= '0;
      entry_active  <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      numbers       <= '0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else begin
      state         <= state_n;
      op_q          <= op_n;
      sp            <= sp_n;
      entry         <= entry_n;
      entry_active  <= active_n;
      err_overflow  <= ovf_n;
      err_underflow <= unf_n;
      numbers       <= numbers_n;
      if (wr_en) stack[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_stack_calc_core.sv
// Bench for stack_calc_core: queue-based RPN model, per-cycle output comparison,
// directed scenarios with literal expectations and a randomized command stream.
module tb_stack_calc_core;
  import calc_pkg::*;

  localparam int W = 16;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic [2:0]   cmd_op = 3'd0;
  logic [3:0]   cmd_digit = 4'd0;
  logic         cmd_ready;
  logic [W-1:0] numbers;
  logic [3:0]   depth;
  logic         entry_active;
  logic         err_overflow;
  logic         err_underflow;

  stack_calc_core #(.DEPTH(D), .WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_op        (cmd_op),
    .cmd_digit     (cmd_digit),
    .cmd_ready     (cmd_ready),
    .numbers       (numbers),
    .depth         (depth),
    .entry_active  (entry_active),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int busy_left = 0;
  bit cmp_en = 1'b0;

  // Reference model: occupied stack entries only, bottom first.
  logic [W-1:0] m_stk [$];
  logic [W-1:0] m_entry;
  logic         m_active;
  logic         m_ovf;
  logic         m_unf;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_entry  = '0;
    m_active = 1'b0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  function automatic logic [W-1:0] m_numbers();
    if (m_active) return m_entry;
    if (m_stk.size() > 0) return m_stk[m_stk.size()-1];
    return '0;
  endfunction

  // Applies one accepted command; busy = number of cycles cmd_ready stays low.
  task automatic model_apply(input logic [2:0] op, input logic [3:0] d, output int busy);
    logic [W-1:0] a, b;
    busy = 0;
    if (op == OP_DIGIT) begin
      m_entry  = {m_entry[W-5:0], d};
      m_active = 1'b1;
      return;
    end
    if (op == OP_CLEAR) begin
      model_reset();
      return;
    end
    if (m_active) begin
      busy     = 1;
      m_active = 1'b0;
      if (m_stk.size() == D) begin
        m_ovf   = 1'b1;
        m_entry = '0;
        return;
      end
      m_stk.push_back(m_entry);
      m_entry = '0;
      if (op == OP_ENTER) return;
    end else if (op == OP_ENTER) begin
      return;
    end
    busy++;
    case (op)
      OP_ADD, OP_SUB, OP_MUL: begin
        if (m_stk.size() < 2) m_unf = 1'b1;
        else begin
          b = m_stk.pop_back();
          a = m_stk.pop_back();
          if (op == OP_ADD)      m_stk.push_back(W'(a + b));
          else if (op == OP_SUB) m_stk.push_back(W'(a - b));
          else                   m_stk.push_back(W'(a * b));
        end
      end
      OP_DROP: begin
        if (m_stk.size() < 1) m_unf = 1'b1;
        else void'(m_stk.pop_back());
      end
      default: begin
        if (m_stk.size() < 1)       m_unf = 1'b1;
        else if (m_stk.size() == D) m_ovf = 1'b1;
        else m_stk.push_back(m_stk[m_stk.size()-1]);
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      if (busy_left > 0) begin
        chk("ready_busy", {31'd0, cmd_ready}, 32'd0);
        busy_left--;
      end else begin
        chk("ready_idle", {31'd0, cmd_ready}, 32'd1);
        chk("numbers", {16'd0, numbers}, {16'd0, m_numbers()});
        chk("depth", {28'd0, depth}, m_stk.size());
        chk("entry_active", {31'd0, entry_active}, {31'd0, m_active});
        chk("err_overflow", {31'd0, err_overflow}, {31'd0, m_ovf});
        chk("err_underflow", {31'd0, err_underflow}, {31'd0, m_unf});
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic issue(input logic [2:0] op, input logic [3:0] d, input bit rst_mid);
    int busy;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_digit = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    model_apply(op, d, busy);
    if (rst_mid && busy > 0) begin
      reset = 1'b1;
      model_reset();
      busy_left = 1;
      @(posedge clk); #1;
      reset = 1'b0;
    end else begin
      busy_left = busy;
    end
    while (busy_left > 0) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 3'($urandom);
      cmd_digit = 4'($urandom);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic digit(input logic [3:0] d);
    issue(OP_DIGIT, d, 1'b0);
  endtask

  task automatic cmd(input logic [2:0] op);
    issue(op, 4'd0, 1'b0);
  endtask

  initial begin
    #4_000_000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int r;
    logic [2:0] op;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_numbers", {16'd0, numbers}, 32'h0);
    chk("rst_depth", {28'd0, depth}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_errs", {30'd0, err_overflow, err_underflow}, 32'd0);
    cmp_en = 1'b1;

    digit(4'h1); digit(4'h9); digit(4'h0); digit(4'h4);
    chk("t1_num", {16'd0, numbers}, 32'h1904);
    chk("t1_model", {16'd0, m_numbers()}, 32'h1904);
    chk("t1_active", {31'd0, entry_active}, 32'd1);
    chk("t1_depth", {28'd0, depth}, 32'd0);

    cmd(OP_CLEAR);
    for (int i = 1; i <= 5; i++) digit(4'(i));
    chk("t2_num", {16'd0, numbers}, 32'h2345);
    chk("t2_errs", {30'd0, err_overflow, err_underflow}, 32'd0);

    cmd(OP_CLEAR);
    digit(4'h5); cmd(OP_ENTER); digit(4'h3); cmd(OP_ENTER); cmd(OP_SUB);
    chk("t3_num", {16'd0, numbers}, 32'h0002);
    chk("t3_depth", {28'd0, depth}, 32'd1);
    digit(4'h3); cmd(OP_SUB);
    chk("t3_wrap", {16'd0, numbers}, 32'hFFFF);
    chk("t3_model", {16'd0, m_numbers()}, 32'hFFFF);
    chk("t3_depth2", {28'd0, depth}, 32'd1);

    cmd(OP_CLEAR);
    digit(4'h1); digit(4'h0); digit(4'h0); cmd(OP_ENTER);
    digit(4'h2); digit(4'h0); digit(4'h0); cmd(OP_ENTER);
    cmd(OP_MUL);
    chk("t4_num", {16'd0, numbers}, 32'h0000);
    chk("t4_depth", {28'd0, depth}, 32'd1);

    cmd(OP_CLEAR);
    cmd(OP_ADD);
    chk("t5_unf", {31'd0, err_underflow}, 32'd1);
    chk("t5_depth", {28'd0, depth}, 32'd0);
    chk("t5_num", {16'd0, numbers}, 32'h0);
    cmd(OP_DROP);
    chk("t5_drop_depth", {28'd0, depth}, 32'd0);
    cmd(OP_CLEAR);
    chk("t5_clear", {31'd0, err_underflow}, 32'd0);

    for (int i = 1; i <= D; i++) begin
      digit(4'(i));
      cmd(OP_ENTER);
    end
    digit(4'h7); cmd(OP_ENTER);
    chk("t6_ovf", {31'd0, err_overflow}, 32'd1);
    chk("t6_depth", {28'd0, depth}, 32'd8);
    chk("t6_active", {31'd0, entry_active}, 32'd0);
    chk("t6_top", {16'd0, numbers}, 32'h0008);
    cmd(OP_DUP);
    chk("t6_dup_depth", {28'd0, depth}, 32'd8);

    issue(OP_ADD, 4'd0, 1'b1);
    chk("t7_num", {16'd0, numbers}, 32'h0);
    chk("t7_depth", {28'd0, depth}, 32'd0);
    chk("t7_flags", {29'd0, entry_active, err_overflow, err_underflow}, 32'd0);
    chk("t7_ready", {31'd0, cmd_ready}, 32'd1);

    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40)      op = OP_DIGIT;
      else if (r < 52) op = OP_ENTER;
      else if (r < 62) op = OP_ADD;
      else if (r < 70) op = OP_SUB;
      else if (r < 78) op = OP_MUL;
      else if (r < 86) op = OP_DROP;
      else if (r < 97) op = OP_DUP;
      else             op = OP_CLEAR;
      issue(op, 4'($urandom), ($urandom_range(0, 49) == 0));
    end

    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
